// File: rtl/bus_reg_slice.sv
// bus_reg_slice: fully registered request/response slice with a 2-entry
// skid buffer per direction. Breaks every combinational path between the
// upstream master and the downstream slave while sustaining 1 beat/cycle.
module bus_reg_slice #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int NUM_BYTES = DATA_WIDTH / 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  // upstream (master-facing) side
  input  logic [1:0]            s_MCmd,
  input  logic [ADDR_WIDTH-1:0] s_MAddr,
  input  logic [DATA_WIDTH-1:0] s_MData,
  input  logic [NUM_BYTES-1:0]  s_MByteEn,
  output logic                  s_SCmdAccept,
  output logic [1:0]            s_SResp,
  output logic [DATA_WIDTH-1:0] s_SData,
  input  logic                  s_MRespAccept,
  // downstream (slave-facing) side
  output logic [1:0]            m_MCmd,
  output logic [ADDR_WIDTH-1:0] m_MAddr,
  output logic [DATA_WIDTH-1:0] m_MData,
  output logic [NUM_BYTES-1:0]  m_MByteEn,
  input  logic                  m_SCmdAccept,
  input  logic [1:0]            m_SResp,
  input  logic [DATA_WIDTH-1:0] m_SData,
  output logic                  m_MRespAccept
);

  // Bus encodings: MCmd IDLE=0 (WR=1, RD=2); SResp NULL=0 (DVA=1).
  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] RESP_NULL = 2'd0;

  // Payloads are carried as flat vectors: {cmd, addr, data, byteen} and {resp, data}.
  localparam int REQ_W = 2 + ADDR_WIDTH + DATA_WIDTH + NUM_BYTES;
  localparam int RSP_W = 2 + DATA_WIDTH;

  typedef enum logic [1:0] {
    REQ_EMPTY = 2'd0,
    REQ_ONE   = 2'd1,
    REQ_TWO   = 2'd2
  } req_state_e;

  typedef enum logic [1:0] {
    RSP_EMPTY = 2'd0,
    RSP_ONE   = 2'd1,
    RSP_TWO   = 2'd2
  } rsp_state_e;

  req_state_e       req_state_q, req_state_d;
  logic [REQ_W-1:0] req_main_q, req_main_d;
  logic [REQ_W-1:0] req_skid_q, req_skid_d;
  logic [REQ_W-1:0] req_in_pl;
  logic             req_in, req_out;

  rsp_state_e       rsp_state_q, rsp_state_d;
  logic [RSP_W-1:0] rsp_main_q, rsp_main_d;
  logic [RSP_W-1:0] rsp_skid_q, rsp_skid_d;
  logic [RSP_W-1:0] rsp_in_pl;
  logic             rsp_in, rsp_out;

  assign req_in_pl = {s_MCmd, s_MAddr, s_MData, s_MByteEn};
  assign rsp_in_pl = {m_SResp, m_SData};

  // Handshakes use only registered accepts, so no input-to-output comb path exists.
  assign req_in  = (s_MCmd != CMD_IDLE) && s_SCmdAccept;
  assign req_out = (m_MCmd != CMD_IDLE) && m_SCmdAccept;
  assign rsp_in  = (m_SResp != RESP_NULL) && m_MRespAccept;
  assign rsp_out = (s_SResp != RESP_NULL) && s_MRespAccept;

  // Payload fields other than the command/response code come straight from the main register.
  assign m_MAddr   = req_main_q[REQ_W-3 -: ADDR_WIDTH];
  assign m_MData   = req_main_q[DATA_WIDTH+NUM_BYTES-1 -: DATA_WIDTH];
  assign m_MByteEn = req_main_q[NUM_BYTES-1:0];
  assign s_SData   = rsp_main_q[DATA_WIDTH-1:0];

  // Request-path state register, main and skid payload registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      req_state_q <= REQ_EMPTY;
      req_main_q  <= '0;
      req_skid_q  <= '0;
    end else begin
      req_state_q <= req_state_d;
      req_main_q  <= req_main_d;
      req_skid_q  <= req_skid_d;
    end
  end

  // Request-path next state: main feeds the slave, skid catches the one beat in flight during a stall.
  always_comb begin
    req_state_d = req_state_q;
    req_main_d  = req_main_q;
    req_skid_d  = req_skid_q;
    case (req_state_q)
      REQ_EMPTY: begin
        if (req_in) begin
          req_state_d = REQ_ONE;
          req_main_d  = req_in_pl;
        end
      end
      REQ_ONE: begin
        if (req_in && req_out) begin
          req_main_d = req_in_pl;
        end else if (req_in) begin
          req_state_d = REQ_TWO;
          req_skid_d  = req_in_pl;
        end else if (req_out) begin
          req_state_d = REQ_EMPTY;
        end
      end
      REQ_TWO: begin
        if (req_out) begin
          req_state_d = REQ_ONE;
          req_main_d  = req_skid_q;
        end
      end
      default: begin
        req_state_d = req_state_e'('x);
        req_main_d  = 'x;
        req_skid_d  = 'x;
      end
    endcase
  end

  // Request-path outputs decoded from the state register only.
  always_comb begin
    s_SCmdAccept = 1'b1;
    m_MCmd       = req_main_q[REQ_W-1 -: 2];
    case (req_state_q)
      REQ_EMPTY: m_MCmd = CMD_IDLE;
      REQ_ONE:   ;
      REQ_TWO:   s_SCmdAccept = 1'b0;
      default: begin
        s_SCmdAccept = 1'bx;
        m_MCmd       = 'x;
      end
    endcase
  end

  // Response-path state register, main and skid payload registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rsp_state_q <= RSP_EMPTY;
      rsp_main_q  <= '0;
      rsp_skid_q  <= '0;
    end else begin
      rsp_state_q <= rsp_state_d;
      rsp_main_q  <= rsp_main_d;
      rsp_skid_q  <= rsp_skid_d;
    end
  end

  // Response-path next state: mirror of the request path in the opposite direction.
  always_comb begin
    rsp_state_d = rsp_state_q;
    rsp_main_d  = rsp_main_q;
    rsp_skid_d  = rsp_skid_q;
    case (rsp_state_q)
      RSP_EMPTY: begin
        if (rsp_in) begin
          rsp_state_d = RSP_ONE;
          rsp_main_d  = rsp_in_pl;
        end
      end
      RSP_ONE: begin
        if (rsp_in && rsp_out) begin
          rsp_main_d = rsp_in_pl;
        end else if (rsp_in) begin
          rsp_state_d = RSP_TWO;
          rsp_skid_d  = rsp_in_pl;
        end else if (rsp_out) begin
          rsp_state_d = RSP_EMPTY;
        end
      end
      RSP_TWO: begin
        if (rsp_out) begin
          rsp_state_d = RSP_ONE;
          rsp_main_d  = rsp_skid_q;
        end
      end
      default: begin
        rsp_state_d = rsp_state_e'('x);
        rsp_main_d  = 'x;
        rsp_skid_d  = 'x;
      end
    endcase
  end

  // Response-path outputs decoded from the state register only.
  always_comb begin
    m_MRespAccept = 1'b1;
    s_SResp       = rsp_main_q[RSP_W-1 -: 2];
    case (rsp_state_q)
      RSP_EMPTY: s_SResp = RESP_NULL;
      RSP_ONE:   ;
      RSP_TWO:   m_MRespAccept = 1'b0;
      default: begin
        m_MRespAccept = 1'bx;
        s_SResp       = 'x;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_reg_slice.sv
// Directed bench for bus_reg_slice with request/response scoreboards.
module tb_bus_reg_slice;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NB = DW / 8;
  localparam int REQ_W = 2 + AW + DW + NB;
  localparam int RSP_W = 2 + DW;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WR    = 2'd1;
  localparam logic [1:0] CMD_RD    = 2'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;

  logic          Clk, Reset;
  logic [1:0]    s_MCmd;
  logic [AW-1:0] s_MAddr;
  logic [DW-1:0] s_MData;
  logic [NB-1:0] s_MByteEn;
  logic          s_SCmdAccept;
  logic [1:0]    s_SResp;
  logic [DW-1:0] s_SData;
  logic          s_MRespAccept;
  logic [1:0]    m_MCmd;
  logic [AW-1:0] m_MAddr;
  logic [DW-1:0] m_MData;
  logic [NB-1:0] m_MByteEn;
  logic          m_SCmdAccept;
  logic [1:0]    m_SResp;
  logic [DW-1:0] m_SData;
  logic          m_MRespAccept;

  bus_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk(Clk), .Reset(Reset),
    .s_MCmd(s_MCmd), .s_MAddr(s_MAddr), .s_MData(s_MData), .s_MByteEn(s_MByteEn),
    .s_SCmdAccept(s_SCmdAccept), .s_SResp(s_SResp), .s_SData(s_SData),
    .s_MRespAccept(s_MRespAccept),
    .m_MCmd(m_MCmd), .m_MAddr(m_MAddr), .m_MData(m_MData), .m_MByteEn(m_MByteEn),
    .m_SCmdAccept(m_SCmdAccept), .m_SResp(m_SResp), .m_SData(m_SData),
    .m_MRespAccept(m_MRespAccept)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  logic [REQ_W-1:0] req_q[$];
  logic [RSP_W-1:0] rsp_q[$];
  logic acc_seen, racc_seen;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: sample #1 after the negedge, settle handshakes against the
  // scoreboards (pop before push so nothing can leave in its own accept cycle),
  // then advance to the next negedge.
  task automatic step();
    logic [REQ_W-1:0] re;
    logic [RSP_W-1:0] pe;
    #1;
    acc_seen  = s_SCmdAccept;
    racc_seen = m_MRespAccept;
    if (m_MCmd != CMD_IDLE && m_SCmdAccept) begin
      if (req_q.size() == 0) chk("req_spurious", 128'(m_MCmd), 128'(CMD_IDLE));
      else begin
        re = req_q.pop_front();
        chk("req_order", 128'({m_MCmd, m_MAddr, m_MData, m_MByteEn}), 128'(re));
      end
    end
    if (s_SResp != RESP_NULL && s_MRespAccept) begin
      if (rsp_q.size() == 0) chk("rsp_spurious", 128'(s_SResp), 128'(RESP_NULL));
      else begin
        pe = rsp_q.pop_front();
        chk("rsp_order", 128'({s_SResp, s_SData}), 128'(pe));
      end
    end
    if (s_MCmd != CMD_IDLE && s_SCmdAccept) req_q.push_back({s_MCmd, s_MAddr, s_MData, s_MByteEn});
    if (m_SResp != RESP_NULL && m_MRespAccept) rsp_q.push_back({m_SResp, m_SData});
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic idle_req();
    s_MCmd = CMD_IDLE; s_MAddr = '0; s_MData = '0; s_MByteEn = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mcmd"}, 128'(m_MCmd), 128'(CMD_IDLE));
    chk({tag, "_maddr"}, 128'(m_MAddr), 128'd0);
    chk({tag, "_mdata"}, 128'(m_MData), 128'd0);
    chk({tag, "_sresp"}, 128'(s_SResp), 128'(RESP_NULL));
    chk({tag, "_sdata"}, 128'(s_SData), 128'd0);
    chk({tag, "_scmdacc"}, 128'(s_SCmdAccept), 128'd1);
    chk({tag, "_mrspacc"}, 128'(m_MRespAccept), 128'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  m_pat, exp_acc;
    logic [31:0] addr;

    Reset = 1'b1;
    idle_req();
    m_SCmdAccept = 1'b1; s_MRespAccept = 1'b1;
    m_SResp = RESP_NULL; m_SData = '0;

    // Reset state.
    #3;
    check_reset_outputs("rst_init");
    @(negedge Clk);
    Reset = 1'b0;
    step();

    // Streaming: four back-to-back writes, each visible one cycle after acceptance.
    for (int i = 0; i < 4; i++) begin
      s_MCmd = CMD_WR; s_MAddr = 32'(4 * i); s_MData = 32'(32'h11 * (i + 1)); s_MByteEn = 4'hf;
      step();
      chk("stream_acc", 128'(acc_seen), 128'd1);
      chk("stream_cmd", 128'(m_MCmd), 128'(CMD_WR));
      chk("stream_addr", 128'(m_MAddr), 128'(4 * i));
      chk("stream_data", 128'(m_MData), 128'(32'h11 * (i + 1)));
    end
    idle_req();
    step();
    step();
    chk("stream_drained", 128'(req_q.size()), 128'd0);

    // Request stall: downstream accept low for three cycles under a continuous read stream.
    m_pat   = 7'b111_0001;
    exp_acc = 7'b110_0011;
    addr    = 32'h200;
    for (int k = 0; k < 7; k++) begin
      s_MCmd = CMD_RD; s_MAddr = addr; s_MData = '0; s_MByteEn = 4'hf;
      m_SCmdAccept = m_pat[k];
      step();
      chk($sformatf("stall_acc_c%0d", k), 128'(acc_seen), 128'(exp_acc[k]));
      if (acc_seen) addr = addr + 32'd4;
      if (k == 3) chk("stall_held", 128'(req_q.size()), 128'd2);
    end
    idle_req();
    m_SCmdAccept = 1'b1;
    for (int k = 0; k < 3; k++) step();
    chk("stall_drained", 128'(req_q.size()), 128'd0);

    // Response stall: two responses land while upstream refuses for four cycles.
    s_MRespAccept = 1'b0;
    m_SResp = RESP_DVA; m_SData = 32'hA5A5A5A5;
    step();
    chk("rstall_racc0", 128'(racc_seen), 128'd1);
    m_SData = 32'hDEADBEEF;
    step();
    chk("rstall_racc1", 128'(racc_seen), 128'd1);
    m_SResp = RESP_NULL; m_SData = '0;
    step();
    chk("rstall_racc2", 128'(racc_seen), 128'd0);
    chk("rstall_sresp", 128'(s_SResp), 128'(RESP_DVA));
    chk("rstall_sdata", 128'(s_SData), 128'(32'hA5A5A5A5));
    step();
    chk("rstall_racc3", 128'(racc_seen), 128'd0);
    s_MRespAccept = 1'b1;
    step();
    chk("rstall_racc4", 128'(racc_seen), 128'd0);
    step();
    chk("rstall_racc5", 128'(racc_seen), 128'd1);
    step();
    chk("rstall_drained", 128'(rsp_q.size()), 128'd0);

    // Simultaneous issue and downstream accept while one request is held.
    s_MCmd = CMD_WR; s_MAddr = 32'h300; s_MData = 32'h1; s_MByteEn = 4'h3;
    step();
    s_MAddr = 32'h304; s_MData = 32'h2; s_MByteEn = 4'hc;
    step();
    chk("simul_acc", 128'(acc_seen), 128'd1);
    chk("simul_cmd", 128'(m_MCmd), 128'(CMD_WR));
    chk("simul_addr", 128'(m_MAddr), 128'(32'h304));
    chk("simul_be", 128'(m_MByteEn), 128'(4'hc));
    chk("simul_scmdacc", 128'(s_SCmdAccept), 128'd1);
    idle_req();
    step();

    // Mid-operation reset with both skid buffers full.
    m_SCmdAccept = 1'b0; s_MRespAccept = 1'b0;
    s_MCmd = CMD_RD; s_MAddr = 32'h400; s_MByteEn = 4'hf;
    m_SResp = RESP_DVA; m_SData = 32'h1;
    step();
    s_MAddr = 32'h404; m_SData = 32'h2;
    step();
    idle_req();
    m_SResp = RESP_NULL; m_SData = '0;
    chk("midrst_req_two", 128'(s_SCmdAccept), 128'd0);
    chk("midrst_rsp_two", 128'(m_MRespAccept), 128'd0);
    #2 Reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    req_q.delete();
    rsp_q.delete();
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    m_SCmdAccept = 1'b1; s_MRespAccept = 1'b1;
    step();
    step();
    chk("post_rst_mcmd", 128'(m_MCmd), 128'(CMD_IDLE));
    chk("post_rst_sresp", 128'(s_SResp), 128'(RESP_NULL));
    s_MCmd = CMD_WR; s_MAddr = 32'h100; s_MData = 32'hCAFE; s_MByteEn = 4'hf;
    step();
    chk("fresh_acc", 128'(acc_seen), 128'd1);
    chk("fresh_cmd", 128'(m_MCmd), 128'(CMD_WR));
    chk("fresh_addr", 128'(m_MAddr), 128'(32'h100));
    chk("fresh_data", 128'(m_MData), 128'(32'hCAFE));
    idle_req();
    step();
    chk("final_req_empty", 128'(req_q.size()), 128'd0);
    chk("final_rsp_empty", 128'(rsp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_reg_slice.md
# bus_reg_slice

Pipeline register slice for the OCP-style system bus, placed directly upstream of the bus-to-RAM bridge (or any other bus slave) to break long timing paths. Fully registers the request path (MCmd/MAddr/MData/MByteEn) toward the slave and the response path (SResp/SData) toward the master, with a 2-entry skid buffer in each direction. Sustains one transaction per cycle when neither side stalls. Preserves order; never drops or duplicates a request or response.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; multiple of 8; NUM_BYTES = DATA_WIDTH/8 (derived, not overridable)
- Clk  in  1  bus clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- s_MCmd  in  Bus::Ocp_cmd  upstream command (IDLE/RD/WR)
- s_MAddr  in  ADDR_WIDTH  upstream address
- s_MData  in  DATA_WIDTH  upstream write data
- s_MByteEn  in  NUM_BYTES  upstream byte enables
- s_SCmdAccept  out  1  request accepted this cycle
- s_SResp  out  Bus::Ocp_resp  response to upstream (NULL/DVA)
- s_SData  out  DATA_WIDTH  read data to upstream
- s_MRespAccept  in  1  upstream accepts response
- m_MCmd, m_MAddr, m_MData, m_MByteEn  out  as s_ side  request to downstream slave
- m_SCmdAccept  in  1  downstream accepts request
- m_SResp  in  Bus::Ocp_resp  downstream response
- m_SData  in  DATA_WIDTH  downstream read data
- m_MRespAccept  out  1  slice accepts downstream response

## Operation
- Request path: main register (drives m_* outputs) plus skid register; 3-state FSM REQ_EMPTY, REQ_ONE, REQ_TWO.
- Upstream handshake: in = (s_MCmd != IDLE) && s_SCmdAccept at an edge. Downstream handshake: out = (m_MCmd != IDLE) && m_SCmdAccept at an edge.
- s_SCmdAccept = (state != REQ_TWO), decoded from the state register only, with no combinational path from m_SCmdAccept or s_MCmd.
- Request-path transitions:
  - REQ_EMPTY: in -> REQ_ONE (main <= s_*).
  - REQ_ONE, in && out: stay (main <= s_*).
  - REQ_ONE, in && !out: -> REQ_TWO (skid <= s_*).
  - REQ_ONE, !in && out: -> REQ_EMPTY.
  - REQ_ONE, neither: hold.
  - REQ_TWO, out: -> REQ_ONE (main <= skid). in is impossible in REQ_TWO.
- m_MCmd = IDLE whenever the state is REQ_EMPTY. In REQ_EMPTY, m_MAddr/m_MData/m_MByteEn keep their last loaded value. Checked only when m_MCmd != IDLE.
- Response path: identical structure (RSP_EMPTY, RSP_ONE, RSP_TWO).
  - in = (m_SResp != NULL) && m_MRespAccept; out = (s_SResp != NULL) && s_MRespAccept.
  - m_MRespAccept = (state != RSP_TWO), from the state register.
  - s_SResp = NULL in RSP_EMPTY.
- Request and response paths are independent; no outstanding-transaction counting.
- Payload is passed through unmodified. No width conversion.
- Downstream slaves that assert SResp in the same cycle as command accept are supported. The response is taken one cycle later by this slice.
- FSM illegal state: outputs X in simulation, next state X.

## Timing
- Reset values (asynchronous, immediate on Reset high):
  - m_MCmd = IDLE; m_MAddr, m_MData, m_MByteEn = 0.
  - s_SResp = NULL; s_SData = 0.
  - s_SCmdAccept = 1; m_MRespAccept = 1.
  - Both FSMs EMPTY; skid registers = 0.
  - Upstream must not issue commands while Reset is high.
- Latency: a request accepted at edge N is visible on m_* in the cycle after edge N (1 cycle). Responses are the same, 1 cycle.
- Throughput: 1 request/cycle and 1 response/cycle with no stalls.
- Backpressure: after m_SCmdAccept goes low, the slice absorbs at most 1 further request (REQ_ONE -> REQ_TWO).
  - s_SCmdAccept then goes low in the following cycle.
  - It returns high in the cycle after the first downstream accept.
- Reset mid-operation clears all in-flight requests and responses without emitting them. The first legal command after Reset deasserts is accepted at the first edge.

## Test plan
- Reset: assert Reset mid-cycle -> all outputs immediately take the reset values above (m_MCmd=IDLE, s_SResp=NULL, both accepts 1).
- Streaming: 4 back-to-back WR to 0x0,0x4,0x8,0xC with data 0x11..0x44 and m_SCmdAccept=1 -> each appears on m_* exactly 1 cycle after acceptance, in order, no gaps.
- Request stall: continuous RD stream with m_SCmdAccept low for 3 cycles -> exactly 2 requests held, s_SCmdAccept low from the 2nd stall cycle, then high 1 cycle after m_SCmdAccept returns; addresses delivered in order, none lost or duplicated.
- Response stall: downstream returns DVA with data 0xA5A5A5A5 then 0xDEADBEEF while s_MRespAccept=0 for 4 cycles -> m_MRespAccept drops after the 2nd response; both are delivered in order once accepted.
- Simultaneous: in REQ_ONE, upstream issue and downstream accept on the same edge -> state stays REQ_ONE, main holds the new request, s_SCmdAccept stays 1.
- Mid-operation reset: Reset pulsed while in REQ_TWO and RSP_TWO -> no stale command or response emitted after release; a fresh WR to 0x100 passes with 1-cycle latency.
